// File: rtl/cell_sequencer.sv
// rtl/cell_sequencer.sv - CellProcessor job sequencer: packs 3x3 pixel pairs into cell vectors, waits out the processor latency, returns each result
package cell_seq_pkg;
   typedef logic [23:0] pixel_t;
   typedef enum logic [2:0] {
      NOP = 3'd0,
      ADD = 3'd1,
      SUB = 3'd2,
      MUL = 3'd3,
      AVG = 3'd4
   } opcodes_t;
endpackage

module cell_sequencer
   import cell_seq_pkg::*;
#(
   parameter int PIXEL_W      = 24,
   parameter int CELL_PIX     = 9,
   parameter int CELL_DEPTH   = 216,
   parameter int PROC_LATENCY = 4,
   parameter int COUNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [COUNT_W-1:0]    cfg_num_cells,
   input  opcodes_t              cfg_opcode,
   input  pixel_t                cfg_user_input,
   input  logic                  pix_valid,
   output logic                  pix_ready,
   input  logic [PIXEL_W-1:0]    pix_a,
   input  logic [PIXEL_W-1:0]    pix_b,
   output logic [CELL_DEPTH-1:0] cell_a,
   output logic [CELL_DEPTH-1:0] cell_b,
   output opcodes_t              opcode,
   output pixel_t                user_input,
   input  pixel_t                proc_pixel,
   output logic                  res_valid,
   input  logic                  res_ready,
   output pixel_t                res_pixel,
   output logic                  busy,
   output logic                  done
);
   localparam int IDX_W = $clog2(CELL_PIX);
   localparam int LAT_W = (PROC_LATENCY > 1) ? $clog2(PROC_LATENCY) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CELL_PIX - 1);
   localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(PROC_LATENCY - 1);

   typedef enum logic [2:0] {IDLE, LOAD, WAIT, OUTPUT, FINISH} state_t;

   state_t             state, state_next;
   logic [IDX_W-1:0]   pix_idx;
   logic [LAT_W-1:0]   lat_cnt;
   logic [COUNT_W-1:0] cells_done, num_cells, cells_next;
   logic               pix_fire, res_fire;

   assign pix_fire   = pix_valid && pix_ready;
   assign res_fire   = res_valid && res_ready;
   assign cells_next = cells_done + COUNT_W'(1);
   assign busy       = (state != IDLE);
   assign done       = (state == FINISH);

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = (cfg_num_cells == '0) ? FINISH : LOAD;
         LOAD:    if (pix_fire && pix_idx == IDX_LAST) state_next = WAIT;
         WAIT:    if (lat_cnt == '0) state_next = OUTPUT;
         OUTPUT:  if (res_fire) state_next = (cells_next == num_cells) ? FINISH : LOAD;
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         pix_ready  <= 1'b0;
         pix_idx    <= '0;
         lat_cnt    <= '0;
         cells_done <= '0;
         num_cells  <= '0;
         cell_a     <= '0;
         cell_b     <= '0;
         opcode     <= NOP;
         user_input <= '0;
         res_valid  <= 1'b0;
         res_pixel  <= '0;
      end else begin
         state     <= state_next;
         // Registered decode so pix_ready never depends combinationally on pix_valid
         pix_ready <= (state_next == LOAD);
         case (state)
            IDLE: if (start) begin
               num_cells  <= cfg_num_cells;
               opcode     <= cfg_opcode;
               user_input <= cfg_user_input;
               cells_done <= '0;
               pix_idx    <= '0;
               cell_a     <= '0;
               cell_b     <= '0;
            end
            LOAD: if (pix_fire) begin
               cell_a[PIXEL_W*pix_idx +: PIXEL_W] <= pix_a;
               cell_b[PIXEL_W*pix_idx +: PIXEL_W] <= pix_b;
               if (pix_idx == IDX_LAST) begin
                  pix_idx <= '0;
                  lat_cnt <= LAT_INIT;
               end else begin
                  pix_idx <= pix_idx + IDX_W'(1);
               end
            end
            WAIT: if (lat_cnt != '0) begin
               lat_cnt <= lat_cnt - LAT_W'(1);
            end else begin
               res_pixel <= proc_pixel;
               res_valid <= 1'b1;
            end
            OUTPUT: if (res_fire) begin
               res_valid  <= 1'b0;
               cells_done <= cells_next;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_cell_sequencer.sv
// tb/tb_cell_sequencer.sv - directed bench for cell_sequencer with a transaction-level reference model
module tb_cell_sequencer;
   import cell_seq_pkg::*;

   localparam int L = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [15:0]  cfg_num_cells = '0;
   opcodes_t     cfg_opcode = NOP;
   pixel_t       cfg_user_input = '0;
   logic         pix_valid = 1'b0;
   logic         pix_ready;
   logic [23:0]  pix_a = '0;
   logic [23:0]  pix_b = '0;
   logic [215:0] cell_a, cell_b;
   opcodes_t     opcode;
   pixel_t       user_input;
   pixel_t       proc_pixel;
   logic         res_valid;
   logic         res_ready = 1'b0;
   pixel_t       res_pixel;
   logic         busy, done;

   cell_sequencer #(.PROC_LATENCY(L)) dut (
      .clk(clk), .rst(rst), .start(start),
      .cfg_num_cells(cfg_num_cells), .cfg_opcode(cfg_opcode), .cfg_user_input(cfg_user_input),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_a(pix_a), .pix_b(pix_b),
      .cell_a(cell_a), .cell_b(cell_b), .opcode(opcode), .user_input(user_input),
      .proc_pixel(proc_pixel), .res_valid(res_valid), .res_ready(res_ready),
      .res_pixel(res_pixel), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int n = 0;
   int done_cnt = 0;
   int ready_cnt = 0;
   int res_cnt_obs = 0;

   // Model state: job progress expressed as pixel and result counts
   bit       m_active = 0;
   bit       m_done = 0;
   int       m_cells = 0;
   int       m_acc = 0;
   int       m_res = 0;
   int       m_t9 = 0;
   opcodes_t m_op = NOP;
   pixel_t   m_user = '0;
   pixel_t   m_last_res = '0;
   pixel_t   slot_a [9];
   pixel_t   slot_b [9];

   function automatic pixel_t hashf(input int k);
      return 24'h5A0000 ^ 24'(k * 37);
   endfunction

   function automatic bit m_rdy();
      return m_active && (m_res < m_cells) && (m_acc < 9 * (m_res + 1));
   endfunction

   function automatic bit m_vld(input int e);
      return m_active && (m_res < m_cells) && (m_acc == 9 * (m_res + 1)) && (e >= m_t9 + L);
   endfunction

   function automatic logic [215:0] m_cell(input bit b_side);
      logic [215:0] v = '0;
      for (int k = 0; k < 9; k++) v[24*k +: 24] = b_side ? slot_b[k] : slot_a[k];
      return v;
   endfunction

   task automatic chk(input string nm, input logic [215:0] got, input logic [215:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, got, exp, n);
      end
   endtask

   task automatic model_step();
      bit rdy, vld, was_active, was_done;
      if (!rst) begin
         m_active = 0; m_done = 0; m_cells = 0; m_acc = 0; m_res = 0; m_t9 = 0;
         m_op = NOP; m_user = '0; m_last_res = '0;
         for (int k = 0; k < 9; k++) begin slot_a[k] = '0; slot_b[k] = '0; end
         return;
      end
      rdy = m_rdy();
      vld = m_vld(n - 1);
      was_active = m_active;
      was_done = m_done;
      m_done = 0;
      if (was_done) m_active = 0;
      if (!was_active && start) begin
         m_active = 1; m_cells = int'(cfg_num_cells); m_acc = 0; m_res = 0;
         m_op = cfg_opcode; m_user = cfg_user_input;
         for (int k = 0; k < 9; k++) begin slot_a[k] = '0; slot_b[k] = '0; end
         if (cfg_num_cells == 0) m_done = 1;
      end
      if (rdy && pix_valid) begin
         slot_a[m_acc % 9] = pix_a;
         slot_b[m_acc % 9] = pix_b;
         m_acc++;
         if (m_acc % 9 == 0) m_t9 = n;
      end
      if (vld && res_ready) begin
         m_res++;
         if (m_res == m_cells) m_done = 1;
      end
      if (m_active && m_res < m_cells && m_acc == 9 * (m_res + 1) && n == m_t9 + L)
         m_last_res = hashf(n);
   endtask

   // Processor stand-in: the value sampled at edge k is hashf(k), so the capture edge is visible
   initial begin
      proc_pixel = hashf(1);
      forever begin
         @(posedge clk);
         n++;
         model_step();
         @(negedge clk);
         chk("pix_ready", pix_ready, m_rdy());
         chk("res_valid", res_valid, m_vld(n));
         chk("busy", busy, m_active);
         chk("done", done, m_done);
         chk("opcode", opcode, m_op);
         chk("user_input", user_input, m_user);
         chk("cell_a", cell_a, m_cell(0));
         chk("cell_b", cell_b, m_cell(1));
         chk("res_pixel", res_pixel, m_last_res);
         if (done) done_cnt++;
         if (pix_ready) ready_cnt++;
         if (res_valid && res_ready) res_cnt_obs++;
         proc_pixel = hashf(n + 1);
      end
   end

   task automatic do_start(input int num, input opcodes_t op, input pixel_t ui);
      @(negedge clk);
      cfg_num_cells = 16'(num);
      cfg_opcode = op;
      cfg_user_input = ui;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_pixels(input int npix, input int gap_pct, input logic [23:0] base,
                             output int acc, output int e9);
      bit rdy_prev;
      int cyc;
      rdy_prev = 0; cyc = 0; acc = 0; e9 = -1;
      while (acc < npix && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (pix_valid && rdy_prev) begin
            acc++;
            e9 = n;
         end
         if (acc < npix) begin
            pix_valid = ($urandom_range(99) >= gap_pct);
            pix_a = base + 24'(acc + 1);
            pix_b = base + 24'((acc + 1) * 16);
         end else begin
            pix_valid = 1'b0;
         end
         rdy_prev = pix_ready;
      end
      pix_valid = 1'b0;
      if (acc < npix) chk("pix_timeout", 216'(acc), 216'(npix));
   endtask

   task automatic wait_valid(output int e);
      int c;
      c = 0; e = -1;
      while (!res_valid && c < 100) begin
         @(negedge clk);
         c++;
      end
      if (res_valid) e = n;
      else chk("res_valid_timeout", 216'(0), 216'(1));
   endtask

   task automatic wait_idle();
      int c;
      c = 0;
      while (busy && c < 300) begin
         @(negedge clk);
         c++;
      end
      if (busy) chk("idle_timeout", 216'(1), 216'(0));
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int acc, e9, ev, d0, r0, rc0;
      pixel_t held;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_pix_ready", pix_ready, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cell_a", cell_a, 0);
      chk("rst_opcode", opcode, 0);
      chk("rst_res_pixel", res_pixel, 0);
      rst = 1'b1;

      // Single cell
      res_ready = 1'b1;
      d0 = done_cnt;
      do_start(1, ADD, 24'h123456);
      run_pixels(9, 0, 24'h000000, acc, e9);
      chk("single_cell_a", cell_a, 216'h000009000008000007000006000005000004000003000002000001);
      chk("single_cell_b", cell_b, 216'h000090000080000070000060000050000040000030000020000010);
      wait_valid(ev);
      chk("single_latency", 216'(ev - e9), 216'(4));
      chk("single_res_pixel", res_pixel, hashf(e9 + 4));
      wait_idle();
      chk("single_done_count", 216'(done_cnt - d0), 216'(1));

      // Input gaps, two cells
      d0 = done_cnt; r0 = res_cnt_obs;
      do_start(2, MUL, 24'h00ABCD);
      run_pixels(18, 50, 24'h100000, acc, e9);
      chk("gaps_accepted", 216'(acc), 216'(18));
      wait_idle();
      chk("gaps_results", 216'(res_cnt_obs - r0), 216'(2));
      chk("gaps_done_count", 216'(done_cnt - d0), 216'(1));

      // Result back-pressure with upstream still offering pixels
      res_ready = 1'b0;
      d0 = done_cnt;
      do_start(1, ADD, 24'h0000AA);
      run_pixels(9, 0, 24'h200000, acc, e9);
      wait_valid(ev);
      held = res_pixel;
      pix_valid = 1'b1;
      repeat (20) begin
         @(negedge clk);
         chk("bp_res_valid", res_valid, 1);
         chk("bp_res_pixel", res_pixel, held);
         chk("bp_pix_ready", pix_ready, 0);
      end
      pix_valid = 1'b0;
      res_ready = 1'b1;
      wait_idle();
      chk("bp_done_count", 216'(done_cnt - d0), 216'(1));

      // Zero-length job
      d0 = done_cnt; rc0 = ready_cnt;
      do_start(0, SUB, 24'h000001);
      repeat (4) @(negedge clk);
      chk("zero_ready_count", 216'(ready_cnt - rc0), 216'(0));
      chk("zero_done_count", 216'(done_cnt - d0), 216'(1));
      chk("zero_busy", busy, 0);

      // Start while busy is ignored
      d0 = done_cnt; r0 = res_cnt_obs;
      do_start(1, ADD, 24'h0F0F0F);
      run_pixels(4, 0, 24'h300000, acc, e9);
      do_start(5, SUB, 24'hFFFFFF);
      chk("busy_start_opcode", opcode, ADD);
      chk("busy_start_user", user_input, 24'h0F0F0F);
      run_pixels(5, 0, 24'h380000, acc, e9);
      wait_idle();
      chk("busy_start_results", 216'(res_cnt_obs - r0), 216'(1));
      chk("busy_start_done", 216'(done_cnt - d0), 216'(1));

      // Reset during WAIT
      d0 = done_cnt;
      do_start(1, ADD, 24'h111111);
      run_pixels(9, 0, 24'h400000, acc, e9);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_pix_ready", pix_ready, 0);
      chk("mid_rst_res_valid", res_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_cell_a", cell_a, 0);
      chk("mid_rst_cell_b", cell_b, 0);
      chk("mid_rst_res_pixel", res_pixel, 0);
      chk("mid_rst_opcode", opcode, 0);
      chk("mid_rst_user", user_input, 0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("mid_rst_no_done", 216'(done_cnt - d0), 216'(0));
      d0 = done_cnt;
      do_start(1, SUB, 24'h222222);
      run_pixels(9, 0, 24'h500000, acc, e9);
      wait_valid(ev);
      chk("post_rst_latency", 216'(ev - e9), 216'(4));
      wait_idle();
      chk("post_rst_done", 216'(done_cnt - d0), 216'(1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1);
   end
endmodule
